spi_slave_core: RTL and testbench

SPI responder for the far end of the team's APB SPI master link: receives SCLK, SS and MOSI, and drives MISO. All logic runs in the PCLK domain. SPI inputs are synchronised and SCLK edges are detected by oversampling. It provides a single-entry TX holding buffer and a single-entry RX buffer with valid/overrun flags, for attachment to an APB register wrapper. It supports all four CPOL/CPHA modes and MSB- or LSB-first ordering, matching the master's framing.

---
 rtl/spi_slave_core_if.sv | 44 ++++
 rtl/spi_slave_core.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_core.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_core_if.sv
// Signal bundle between spi_slave_core and its host: SPI pins, mode controls and buffer handshakes.
interface spi_slave_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  spi_en;
  logic                  cpol;
  logic                  cpha;
  logic                  lsbfe;
  logic                  ss_in;
  logic                  sclk_in;
  logic                  mosi_in;
  logic                  miso_out;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_empty;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_read;
  logic                  rx_overrun;
  logic                  busy;

  modport slave (
    input  spi_en, cpol, cpha, lsbfe,
    input  ss_in, sclk_in, mosi_in,
    output miso_out, miso_oe,
    input  tx_data, tx_load,
    output tx_empty,
    output rx_data, rx_valid, rx_overrun,
    input  rx_read,
    output busy
  );

  modport master (
    output spi_en, cpol, cpha, lsbfe,
    output ss_in, sclk_in, mosi_in,
    input  miso_out, miso_oe,
    output tx_data, tx_load,
    input  tx_empty,
    input  rx_data, rx_valid, rx_overrun,
    output rx_read,
    input  busy
  );
endinterface

// File: rtl/spi_slave_core.sv
// SPI responder running entirely in the PCLK domain: oversampled SCLK edge detection,
// single-entry TX holding buffer and single-entry RX buffer with valid/overrun flags.
module spi_slave_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic             PCLK,
  input logic             PRESETn,
  spi_slave_core_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    XFER
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  ss_sync;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    ss_d;
  logic                    sclk_d;
  logic                    ss_s;
  logic                    sclk_s;
  logic                    mosi_s;
  logic                    ss_fall;
  logic                    ss_rise;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    lead_edge;
  logic                    trail_edge;
  logic                    sample_edge;
  logic                    shift_edge;
  logic [CNT_W-1:0]        bitcnt;
  logic [DATA_WIDTH-1:0]   tx_shreg;
  logic [DATA_WIDTH-1:0]   tx_shreg_next;
  logic [DATA_WIDTH-1:0]   rx_shreg;
  logic [DATA_WIDTH-1:0]   rx_next;
  logic [DATA_WIDTH-1:0]   tx_buf;
  logic                    tx_empty_r;
  logic [DATA_WIDTH-1:0]   rx_data_r;
  logic                    rx_valid_r;
  logic                    rx_overrun_r;
  logic                    miso_oe_r;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss_in};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_in};
      ss_d      <= ss_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  assign lead_edge   = bus.cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = bus.cpol ? sclk_rise : sclk_fall;
  assign sample_edge = bus.cpha ? trail_edge : lead_edge;
  assign shift_edge  = bus.cpha ? lead_edge : trail_edge;

  assign rx_next       = bus.lsbfe ? {mosi_s, rx_shreg[DATA_WIDTH-1:1]}
                                   : {rx_shreg[DATA_WIDTH-2:0], mosi_s};
  assign tx_shreg_next = bus.lsbfe ? (tx_shreg >> 1) : (tx_shreg << 1);

  // Shift edges are only honoured once a bit of the current frame has been sampled:
  // this skips the first leading edge with cpha=1 and the trailing edge that follows a
  // completed frame with cpha=0, which would otherwise clobber the freshly loaded word.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state        <= IDLE;
      bitcnt       <= '0;
      tx_shreg     <= '0;
      rx_shreg     <= '0;
      tx_buf       <= '0;
      tx_empty_r   <= 1'b1;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      rx_overrun_r <= 1'b0;
      miso_oe_r    <= 1'b0;
    end else if (!bus.spi_en) begin
      state        <= IDLE;
      bitcnt       <= '0;
      tx_empty_r   <= 1'b1;
      rx_valid_r   <= 1'b0;
      rx_overrun_r <= 1'b0;
      miso_oe_r    <= 1'b0;
    end else begin
      miso_oe_r <= ~ss_s;

      if (bus.tx_load) begin
        tx_buf     <= bus.tx_data;
        tx_empty_r <= 1'b0;
      end

      if (bus.rx_read && rx_valid_r) begin
        rx_valid_r   <= 1'b0;
        rx_overrun_r <= 1'b0;
      end

      case (state)
        IDLE: begin
          bitcnt <= '0;
          if (ss_fall) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          tx_shreg <= tx_empty_r ? '1 : tx_buf;
          if (!bus.tx_load) begin
            tx_empty_r <= 1'b1;
          end
          rx_shreg <= '0;
          bitcnt   <= '0;
          state    <= ss_rise ? IDLE : XFER;
        end

        XFER: begin
          if (ss_rise) begin
            state  <= IDLE;
            bitcnt <= '0;
          end else if (sample_edge) begin
            rx_shreg <= rx_next;
            if (bitcnt == LAST_BIT) begin
              bitcnt <= '0;
              state  <= ss_s ? IDLE : LOAD;
              if (!rx_valid_r || bus.rx_read) begin
                rx_data_r  <= rx_next;
                rx_valid_r <= 1'b1;
              end else begin
                rx_overrun_r <= 1'b1;
              end
            end else begin
              bitcnt <= bitcnt + CNT_W'(1);
            end
          end else if (shift_edge && (bitcnt != '0)) begin
            tx_shreg <= tx_shreg_next;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.miso_out   = bus.lsbfe ? tx_shreg[0] : tx_shreg[DATA_WIDTH-1];
  assign bus.miso_oe    = miso_oe_r;
  assign bus.tx_empty   = tx_empty_r;
  assign bus.rx_data    = rx_data_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.rx_overrun = rx_overrun_r;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: the bench plays the SPI master and the APB-side host.
module tb_spi_slave_core;

  localparam int HALF = 8;

  logic PCLK;
  logic PRESETn;
  int   n_checks;
  int   n_fail;
  logic [7:0] miso_byte;

  spi_slave_core_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_core #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus.slave)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pulse_tx_load(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    wait_cycles(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic pulse_rx_read();
    bus.rx_read = 1'b1;
    wait_cycles(1);
    bus.rx_read = 1'b0;
    wait_cycles(1);
  endtask

  task automatic ss_low();
    bus.ss_in = 1'b0;
    wait_cycles(HALF);
  endtask

  task automatic ss_high();
    wait_cycles(HALF);
    bus.ss_in = 1'b1;
    wait_cycles(HALF);
  endtask

  // Master side of one frame: drives MOSI and captures MISO on the edges the mode dictates.
  task automatic applyStimulus(input logic [7:0] mosi_byte, input int nbits,
                               output logic [7:0] captured);
    logic idle_lvl;
    int   idx;
    captured = '0;
    idle_lvl = bus.cpol;
    for (int i = 0; i < nbits; i++) begin
      idx = bus.lsbfe ? i : 7 - i;
      if (!bus.cpha) begin
        bus.mosi_in = mosi_byte[idx];
        wait_cycles(HALF);
        bus.sclk_in   = ~idle_lvl;
        captured[idx] = bus.miso_out;
        wait_cycles(HALF);
        bus.sclk_in = idle_lvl;
      end else begin
        wait_cycles(HALF);
        bus.sclk_in = ~idle_lvl;
        bus.mosi_in = mosi_byte[idx];
        wait_cycles(HALF);
        bus.sclk_in   = idle_lvl;
        captured[idx] = bus.miso_out;
      end
    end
    wait_cycles(6);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    bus.cpol    = pol;
    bus.cpha    = pha;
    bus.lsbfe   = lsb;
    bus.sclk_in = pol;
    wait_cycles(HALF);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    PRESETn     = 1'b0;
    bus.spi_en  = 1'b1;
    bus.cpol    = 1'b0;
    bus.cpha    = 1'b0;
    bus.lsbfe   = 1'b0;
    bus.ss_in   = 1'b1;
    bus.sclk_in = 1'b0;
    bus.mosi_in = 1'b0;
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    bus.rx_read = 1'b0;

    wait_cycles(4);
    checkOutput("rst_miso_out",   bus.miso_out,   0);
    checkOutput("rst_miso_oe",    bus.miso_oe,    0);
    checkOutput("rst_tx_empty",   bus.tx_empty,   1);
    checkOutput("rst_rx_data",    bus.rx_data,    0);
    checkOutput("rst_rx_valid",   bus.rx_valid,   0);
    checkOutput("rst_rx_overrun", bus.rx_overrun, 0);
    checkOutput("rst_busy",       bus.busy,       0);
    PRESETn = 1'b1;
    wait_cycles(4);

    // Mode 0, MSB first
    $display("[TB] mode 0 MSB-first frame");
    pulse_tx_load(8'h3C);
    checkOutput("m0_tx_full", bus.tx_empty, 0);
    ss_low();
    checkOutput("m0_busy", bus.busy, 1);
    checkOutput("m0_miso_oe", bus.miso_oe, 1);
    applyStimulus(8'hA5, 8, miso_byte);
    checkOutput("m0_miso_bits", miso_byte, 8'h3C);
    checkOutput("m0_rx_data", bus.rx_data, 8'hA5);
    checkOutput("m0_rx_valid", bus.rx_valid, 1);
    checkOutput("m0_tx_empty", bus.tx_empty, 1);
    ss_high();
    checkOutput("m0_idle", bus.busy, 0);
    pulse_rx_read();
    checkOutput("m0_read_clr", bus.rx_valid, 0);

    // Mode 3, LSB first
    $display("[TB] mode 3 LSB-first frame");
    set_mode(1'b1, 1'b1, 1'b1);
    pulse_tx_load(8'h81);
    ss_low();
    applyStimulus(8'h0F, 8, miso_byte);
    checkOutput("m3_miso_bits", miso_byte, 8'h81);
    checkOutput("m3_rx_data", bus.rx_data, 8'h0F);
    checkOutput("m3_rx_valid", bus.rx_valid, 1);
    ss_high();
    pulse_rx_read();

    // Back-to-back frames in one SS window
    $display("[TB] back-to-back frames");
    set_mode(1'b0, 1'b0, 1'b0);
    pulse_tx_load(8'h5A);
    ss_low();
    checkOutput("b2b_load1_empty", bus.tx_empty, 1);
    pulse_tx_load(8'hC3);
    checkOutput("b2b_reload_full", bus.tx_empty, 0);
    applyStimulus(8'h11, 8, miso_byte);
    checkOutput("b2b_miso1", miso_byte, 8'h5A);
    checkOutput("b2b_rx1", bus.rx_data, 8'h11);
    checkOutput("b2b_tx_consumed", bus.tx_empty, 1);
    pulse_rx_read();
    checkOutput("b2b_read1", bus.rx_valid, 0);
    applyStimulus(8'h22, 8, miso_byte);
    checkOutput("b2b_miso2", miso_byte, 8'hC3);
    checkOutput("b2b_rx2", bus.rx_data, 8'h22);
    checkOutput("b2b_valid2", bus.rx_valid, 1);
    checkOutput("b2b_no_ovr", bus.rx_overrun, 0);
    ss_high();
    pulse_rx_read();

    // Overrun with underrun pattern on MISO
    $display("[TB] overrun");
    ss_low();
    applyStimulus(8'h33, 8, miso_byte);
    checkOutput("ovr_underrun_ff", miso_byte, 8'hFF);
    ss_high();
    ss_low();
    applyStimulus(8'h44, 8, miso_byte);
    ss_high();
    checkOutput("ovr_rx_kept", bus.rx_data, 8'h33);
    checkOutput("ovr_flag", bus.rx_overrun, 1);
    checkOutput("ovr_valid", bus.rx_valid, 1);
    pulse_rx_read();
    checkOutput("ovr_clr_valid", bus.rx_valid, 0);
    checkOutput("ovr_clr_flag", bus.rx_overrun, 0);

    // Abort after 5 bits
    $display("[TB] abort after 5 bits");
    ss_low();
    applyStimulus(8'h96, 5, miso_byte);
    checkOutput("abort_miso", miso_byte, 8'hF8);
    ss_high();
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_valid", bus.rx_valid, 0);

    // spi_en dropped mid-frame
    $display("[TB] spi_en drop");
    ss_low();
    pulse_tx_load(8'h77);
    applyStimulus(8'h00, 3, miso_byte);
    checkOutput("en_pre_oe", bus.miso_oe, 1);
    checkOutput("en_pre_full", bus.tx_empty, 0);
    bus.spi_en = 1'b0;
    wait_cycles(1);
    checkOutput("en_drop_oe", bus.miso_oe, 0);
    checkOutput("en_drop_empty", bus.tx_empty, 1);
    checkOutput("en_drop_busy", bus.busy, 0);
    bus.ss_in = 1'b1;
    wait_cycles(HALF);
    bus.spi_en = 1'b1;
    wait_cycles(HALF);

    // PRESETn pulse mid-frame
    $display("[TB] reset mid-frame");
    ss_low();
    applyStimulus(8'h5C, 8, miso_byte);
    checkOutput("rst_pre_rx", bus.rx_data, 8'h5C);
    pulse_tx_load(8'hAB);
    applyStimulus(8'hFF, 3, miso_byte);
    checkOutput("rst_pre_busy", bus.busy, 1);
    bus.ss_in = 1'b1;
    PRESETn   = 1'b0;
    #2;
    checkOutput("mid_rst_miso_out",   bus.miso_out,   0);
    checkOutput("mid_rst_miso_oe",    bus.miso_oe,    0);
    checkOutput("mid_rst_tx_empty",   bus.tx_empty,   1);
    checkOutput("mid_rst_rx_data",    bus.rx_data,    0);
    checkOutput("mid_rst_rx_valid",   bus.rx_valid,   0);
    checkOutput("mid_rst_rx_overrun", bus.rx_overrun, 0);
    checkOutput("mid_rst_busy",       bus.busy,       0);
    wait_cycles(4);
    PRESETn = 1'b1;
    wait_cycles(HALF);
    checkOutput("post_rst_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
